// File: rtl/mc_datapath_regs_pkg.sv
// Shared MIPS encodings for the multicycle datapath and its control FSM.
// Includes the J-type jump-target helper used by the PC unit.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_JMP  = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // 2'b11 is deliberately left out: it is the illegal PCSource code
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    SRCB_B       = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] instr);
    return {pc[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/mc_datapath_regs_pc_unit.sv
// Program counter: conditional load enable, next-PC select and a sticky
// flag for an illegal PCSource seen while the PC is being written.
module pc_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pc_write,
  input  logic             i_pc_write_cond,
  input  logic             i_alu_zero,
  input  logic [1:0]       i_pc_source,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic [WIDTH-1:0] i_instr,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_pcsrc_err
);

  logic [WIDTH-1:0] r_pc;
  logic             r_pcsrc_err;
  logic             w_pc_en;
  logic             w_illegal;
  logic [WIDTH-1:0] w_pc_next;

  assign w_pc_en = i_pc_write | (i_pc_write_cond & i_alu_zero);

  // PCSource only matters when the PC is actually being loaded
  always_comb begin
    w_pc_next = r_pc;
    w_illegal = 1'b0;
    if (w_pc_en) begin
      case (i_pc_source)
        PCSRC_ALU:    w_pc_next = i_alu_result;
        PCSRC_ALUOUT: w_pc_next = i_alu_out;
        PCSRC_JUMP:   w_pc_next = jump_target(r_pc, i_instr);
        default:      w_illegal = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_pcsrc_err <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_illegal) r_pcsrc_err <= 1'b1;
    end
  end

  assign o_pc        = r_pc;
  assign o_pcsrc_err = r_pcsrc_err;

endmodule

// File: rtl/mc_datapath_regs.sv
// Multicycle MIPS datapath registers: IR, MDR, A, B, ALUOut, memory address
// select and instruction decode fields, with the PC in pc_unit.
module mc_datapath_regs
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic [1:0]       PCSource,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] rf_rdata1,
  input  logic [WIDTH-1:0] rf_rdata2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [5:0]       funct,
  output logic [WIDTH-1:0] imm_sext,
  output logic [WIDTH-1:0] imm_sext_sh2,
  output logic [WIDTH-1:0] mdr,
  output logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] b_reg,
  output logic [WIDTH-1:0] alu_out,
  output logic             pcsrc_err
);

  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_alu_out;
  logic [WIDTH-1:0] w_pc;

  pc_unit #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc_unit (
    .clk            (clk),
    .rst            (rst),
    .i_pc_write     (PCWrite),
    .i_pc_write_cond(PCWriteCond),
    .i_alu_zero     (alu_zero),
    .i_pc_source    (PCSource),
    .i_alu_result   (alu_result),
    .i_alu_out      (r_alu_out),
    .i_instr        (r_instr),
    .o_pc           (w_pc),
    .o_pcsrc_err    (pcsrc_err)
  );

  // Jump target inside pc_unit sees this pre-edge IR, even during FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr   <= '0;
      r_mdr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
    end else begin
      if (IRWrite) r_instr <= mem_rdata;
      r_mdr     <= mem_rdata;
      r_a       <= rf_rdata1;
      r_b       <= rf_rdata2;
      r_alu_out <= alu_result;
    end
  end

  assign pc           = w_pc;
  assign mem_addr     = IorD ? r_alu_out : w_pc;
  assign instr        = r_instr;
  assign opcode       = r_instr[31:26];
  assign rs           = r_instr[25:21];
  assign rt           = r_instr[20:16];
  assign rd           = r_instr[15:11];
  assign funct        = r_instr[5:0];
  assign imm_sext     = {{(WIDTH-16){r_instr[15]}}, r_instr[15:0]};
  assign imm_sext_sh2 = {imm_sext[WIDTH-3:0], 2'b00};
  assign mdr          = r_mdr;
  assign a_reg        = r_a;
  assign b_reg        = r_b;
  assign alu_out      = r_alu_out;

endmodule
